// File: rtl/keccak_obi_responder.sv
// OBI slave front-end for the Keccak permutation core.
// Holds the 1600-bit input state, captures the output state on completion,
// and provides CTRL/STATUS/IEN registers. DIN writes are stalled while the
// core is running. The IEN register and the interrupt output exist only when
// the KECCAK_IRQ_EN macro is defined; otherwise intr_o is tied low.
module keccak_obi_responder #(
  // Must be at most 127 so the word index fits the 0x200-byte window.
  parameter int unsigned STATE_WORDS = 50
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      req_i,
  input  logic                      we_i,
  input  logic [3:0]                be_i,
  input  logic [31:0]               addr_i,
  input  logic [31:0]               wdata_i,
  output logic                      gnt_o,
  output logic                      rvalid_o,
  output logic [31:0]               rdata_o,
  output logic                      start_o,
  output logic [32*STATE_WORDS-1:0] din_o,
  input  logic [32*STATE_WORDS-1:0] dout_i,
  input  logic                      done_i,
  output logic                      intr_o
);

  localparam int unsigned IdxW     = $clog2(STATE_WORDS);
  localparam logic [6:0]  NumWords = 7'(STATE_WORDS);

  typedef enum logic {StIdle, StRun} state_e;

  state_e      state_q;
  logic        start_q;
  logic        done_q;
  logic        rvalid_q;
  logic [31:0] rdata_q;
  logic [31:0] din_q  [STATE_WORDS];
  logic [31:0] dout_q [STATE_WORDS];
  logic        ien;

  // Address decode; only addr_i[19:0] participate, bits [1:0] are ignored.
  logic [6:0]      word_sel;
  logic            word_ok;
  logic [IdxW-1:0] word_idx;
  logic            win;
  logic            din_hit;
  logic            dout_hit;
  logic            ctrl_hit;
  logic            status_hit;
  logic            ien_hit;

  assign word_sel   = addr_i[8:2];
  assign word_ok    = word_sel < NumWords;
  assign word_idx   = word_sel[IdxW-1:0];
  assign win        = addr_i[19:11] == 9'd0;
  assign din_hit    = win && (addr_i[10:9] == 2'b00) && word_ok;
  assign dout_hit   = win && (addr_i[10:9] == 2'b01) && word_ok;
  assign ctrl_hit   = win && (addr_i[10:2] == 9'h100);
  assign status_hit = win && (addr_i[10:2] == 9'h101);
  assign ien_hit    = win && (addr_i[10:2] == 9'h102);

  logic unused_addr;
  assign unused_addr = ^{addr_i[31:20], addr_i[1:0]};

  // Handshake: only a DIN write during a run is held off.
  logic busy;
  logic stall;
  logic gnt;
  logic wr_acc;
  logic rd_acc;
  logic ctrl_start;
  logic status_rd;

  assign busy       = state_q == StRun;
  assign stall      = busy && we_i && din_hit;
  assign gnt        = req_i && !stall;
  assign wr_acc     = gnt && we_i;
  assign rd_acc     = gnt && !we_i;
  assign ctrl_start = wr_acc && ctrl_hit && wdata_i[0];
  assign status_rd  = rd_acc && status_hit;

  assign gnt_o    = gnt;
  assign rvalid_o = rvalid_q;
  assign rdata_o  = rdata_q;
  assign start_o  = start_q;

  // Read data mux for the addressed register.
  logic [31:0] rd_data;
  always_comb begin
    rd_data = 32'h0;
    if (din_hit) begin
      rd_data = din_q[word_idx];
    end else if (dout_hit) begin
      rd_data = dout_q[word_idx];
    end else if (status_hit) begin
      rd_data = {30'h0, done_q, busy};
    end else if (ien_hit) begin
      rd_data = {31'h0, ien};
    end
  end

  // Response channel: one rvalid per granted request, zero data on writes.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rvalid_q <= 1'b0;
      rdata_q  <= 32'h0;
    end else begin
      rvalid_q <= gnt;
      rdata_q  <= rd_acc ? rd_data : 32'h0;
    end
  end

  // Input state bank with per-byte write enables.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned k = 0; k < STATE_WORDS; k++) begin
        din_q[k] <= 32'h0;
      end
    end else if (wr_acc && din_hit) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (be_i[b]) begin
          din_q[word_idx][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

  for (genvar g = 0; g < STATE_WORDS; g++) begin : g_din_flat
    assign din_o[32*g +: 32] = din_q[g];
  end

  // Run-control FSM with start pulse, sticky done flag and output capture.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      start_q <= 1'b0;
      done_q  <= 1'b0;
      for (int unsigned k = 0; k < STATE_WORDS; k++) begin
        dout_q[k] <= 32'h0;
      end
    end else begin
      start_q <= 1'b0;
      // Clear-on-read comes first so a done set in this same cycle survives.
      if (status_rd && done_q) begin
        done_q <= 1'b0;
      end
      unique case (state_q)
        StIdle: begin
          if (ctrl_start) begin
            state_q <= StRun;
            start_q <= 1'b1;
            done_q  <= 1'b0;
          end
        end
        StRun: begin
          if (done_i) begin
            state_q <= StIdle;
            done_q  <= 1'b1;
            for (int unsigned k = 0; k < STATE_WORDS; k++) begin
              dout_q[k] <= dout_i[32*k +: 32];
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef KECCAK_IRQ_EN
  logic ien_q;

  // Interrupt enable register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ien_q <= 1'b0;
    end else if (wr_acc && ien_hit) begin
      ien_q <= wdata_i[0];
    end
  end

  assign ien    = ien_q;
  assign intr_o = done_q & ien_q;
`else
  assign ien    = 1'b0;
  assign intr_o = 1'b0;
`endif

endmodule

// File: tb/tb_keccak_obi_responder.sv
// Self-checking bench for keccak_obi_responder: a vector table for register
// accesses plus hand-written run/stall/coincidence sequences. Read data is
// checked through a scoreboard that also pins the rvalid cycle.
module tb_keccak_obi_responder;

  localparam int unsigned W = 50;
`ifdef KECCAK_IRQ_EN
  localparam logic IrqEn = 1'b1;
`else
  localparam logic IrqEn = 1'b0;
`endif

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             req_i;
  logic             we_i;
  logic [3:0]       be_i;
  logic [31:0]      addr_i;
  logic [31:0]      wdata_i;
  logic             gnt_o;
  logic             rvalid_o;
  logic [31:0]      rdata_o;
  logic             start_o;
  logic [32*W-1:0]  din_o;
  logic [32*W-1:0]  dout_i;
  logic             done_i;
  logic             intr_o;

  keccak_obi_responder #(.STATE_WORDS(W)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .req_i   (req_i),
    .we_i    (we_i),
    .be_i    (be_i),
    .addr_i  (addr_i),
    .wdata_i (wdata_i),
    .gnt_o   (gnt_o),
    .rvalid_o(rvalid_o),
    .rdata_o (rdata_o),
    .start_o (start_o),
    .din_o   (din_o),
    .dout_i  (dout_i),
    .done_i  (done_i),
    .intr_o  (intr_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] data;
    int          due;
  } sb_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp;
  } vec_t;

  sb_t  sb[$];
  sb_t  sb_e;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   n_start = 0;
  int   start_cyc = -1;
  int   done_cyc = -1;
  int   wt, gc, wt_a, gc_a, g, n0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Response monitor: pops the scoreboard and checks data and cycle.
  always @(negedge clk_i) begin
    if (start_o) begin
      n_start++;
      start_cyc = cyc;
    end
    if (rvalid_o === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_rvalid", 32'h1, 32'h0);
      end else begin
        sb_e = sb.pop_front();
        chk("rdata", rdata_o, sb_e.data);
        chk("rvalid_cycle", cyc, sb_e.due);
      end
    end else if (sb.size() > 0 && sb[0].due <= cyc) begin
      sb_e = sb.pop_front();
      chk("rvalid_missing", 32'h0, 32'h1);
    end
  end

  // One OBI transaction; starts right after a posedge, ends #1 after the granting edge.
  task automatic bus(input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] b, input logic [31:0] exp,
                     output int waited, output int gcyc);
    req_i = 1'b1; we_i = w; addr_i = a; wdata_i = d; be_i = b;
    waited = 0;
    gcyc = -1;
    while (1) begin
      @(negedge clk_i);
      if (gnt_o) break;
      waited++;
      if (waited > 300) begin
        chk("gnt_timeout", a, 32'hFFFF_FFFF);
        break;
      end
    end
    if (gnt_o) begin
      gcyc = cyc;
      sb.push_back('{exp, cyc + 1});
    end
    @(posedge clk_i);
    #1;
    req_i = 1'b0; we_i = 1'b0; addr_i = 32'h0; wdata_i = 32'h0; be_i = 4'h0;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp);
    bus(1'b0, a, 32'h0, 4'hF, exp, wt, gc);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus(1'b1, a, d, 4'hF, 32'h0, wt, gc);
  endtask

  task automatic pulse_done();
    done_i = 1'b1;
    @(posedge clk_i);
    #1;
    done_cyc = cyc;
    done_i = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  vec_t tbl[$];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl.push_back('{1'b0, 32'h0000_0404, 32'h0,         4'hF, 32'h0});
    tbl.push_back('{1'b1, 32'h0000_0000, 32'hDEADBEEF,  4'h3, 32'h0});
    tbl.push_back('{1'b0, 32'h0000_0000, 32'h0,         4'hF, 32'h0000BEEF});
    tbl.push_back('{1'b1, 32'h0000_0004, 32'hCAFEF00D,  4'hC, 32'h0});
    tbl.push_back('{1'b0, 32'h0000_0004, 32'h0,         4'hF, 32'hCAFE0000});
    tbl.push_back('{1'b1, 32'h0000_00C4, 32'h11223344,  4'hF, 32'h0});
    tbl.push_back('{1'b0, 32'h0000_00C4, 32'h0,         4'hF, 32'h11223344});
    tbl.push_back('{1'b1, 32'h0000_00C8, 32'hAAAA5555,  4'hF, 32'h0});
    tbl.push_back('{1'b0, 32'h0000_00C8, 32'h0,         4'hF, 32'h0});
    tbl.push_back('{1'b1, 32'h0000_0200, 32'h55555555,  4'hF, 32'h0});
    tbl.push_back('{1'b0, 32'h0000_0200, 32'h0,         4'hF, 32'h0});
    tbl.push_back('{1'b1, 32'h0000_0400, 32'h2,         4'hF, 32'h0});
    tbl.push_back('{1'b0, 32'h0000_0400, 32'h0,         4'hF, 32'h0});
    tbl.push_back('{1'b1, 32'h0000_0800, 32'h12345678,  4'hF, 32'h0});
    tbl.push_back('{1'b0, 32'h0000_0800, 32'h0,         4'hF, 32'h0});
    tbl.push_back('{1'b0, 32'h0008_0000, 32'h0,         4'hF, 32'h0});
    tbl.push_back('{1'b0, 32'hFFF0_0000, 32'h0,         4'hF, 32'h0000BEEF});
    tbl.push_back('{1'b1, 32'h0000_0408, 32'h1,         4'hF, 32'h0});
    tbl.push_back('{1'b0, 32'h0000_0408, 32'h0,         4'hF, {31'h0, IrqEn}});

    rst_i = 1'b1; req_i = 1'b0; we_i = 1'b0; be_i = 4'h0; addr_i = 32'h0;
    wdata_i = 32'h0; done_i = 1'b0; dout_i = '0;
    dout_i[32*49 +: 32] = 32'h12345678;
    dout_i[31:0]        = 32'hA5A5A5A5;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_gnt", {31'h0, gnt_o}, 32'h0);
    chk("rst_rvalid", {31'h0, rvalid_o}, 32'h0);
    chk("rst_rdata", rdata_o, 32'h0);
    chk("rst_start", {31'h0, start_o}, 32'h0);
    chk("rst_din_zero", {31'h0, |din_o}, 32'h0);
    chk("rst_intr", {31'h0, intr_o}, 32'h0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;

    // Register map, back-to-back, no wait states in IDLE.
    foreach (tbl[i]) begin
      bus(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].be, tbl[i].exp, wt, gc);
      chk("tbl_gnt_wait", wt, 0);
    end
    idle(2);
    chk("din0_port", din_o[31:0], 32'h0000BEEF);
    chk("din49_port", din_o[32*49 +: 32], 32'h11223344);
    chk("ctrl_bit0_clear_no_start", n_start, 0);
    chk("intr_idle", {31'h0, intr_o}, 32'h0);

    // Run 1: start, busy, start-while-run ignored, completion and capture.
    n0 = n_start;
    bus(1'b1, 32'h400, 32'h1, 4'hF, 32'h0, wt, g);
    rd(32'h404, 32'h1);
    chk("start_cycle", start_cyc, g + 1);
    rd(32'h2C4, 32'h0);
    chk("dout_rd_no_stall", wt, 0);
    wr(32'h400, 32'h1);
    chk("ctrl_in_run_gnt", wt, 0);
    idle(18);
    chk("intr_before_done", {31'h0, intr_o}, 32'h0);
    pulse_done();
    chk("intr_after_done", {31'h0, intr_o}, {31'h0, IrqEn});
    chk("start_count_run1", n_start, n0 + 1);
    rd(32'h2C4, 32'h12345678);
    rd(32'h200, 32'hA5A5A5A5);
    rd(32'h404, 32'h2);
    chk("intr_cleared_by_read", {31'h0, intr_o}, 32'h0);
    rd(32'h404, 32'h0);

    // Run 2: DIN write stalled until the first IDLE cycle.
    wr(32'h400, 32'h1);
    rd(32'h404, 32'h1);
    fork
      bus(1'b1, 32'h00C, 32'h0BADF00D, 4'hF, 32'h0, wt_a, gc_a);
      begin
        idle(10);
        pulse_done();
      end
    join
    chk("stall_grant_cycle", gc_a, done_cyc);
    chk("stall_waited", {31'h0, wt_a > 0}, 32'h1);
    rd(32'h00C, 32'h0BADF00D);
    chk("din3_port", din_o[32*3 +: 32], 32'h0BADF00D);
    rd(32'h404, 32'h2);

    // Run 3: STATUS read coinciding with done returns pre-edge value, done survives.
    wr(32'h400, 32'h1);
    idle(5);
    done_i = 1'b1;
    rd(32'h404, 32'h1);
    done_i = 1'b0;
    chk("intr_after_coincide_rd", {31'h0, intr_o}, {31'h0, IrqEn});
    rd(32'h404, 32'h2);
    rd(32'h404, 32'h0);

    // Run 4: start write coinciding with done is ignored.
    n0 = n_start;
    wr(32'h400, 32'h1);
    idle(5);
    done_i = 1'b1;
    wr(32'h400, 32'h1);
    done_i = 1'b0;
    idle(2);
    chk("coincide_no_restart", n_start, n0 + 1);
    rd(32'h404, 32'h2);
    wr(32'h010, 32'h600DCAFE);
    chk("din_wr_idle_no_stall", wt, 0);

    // done_i while IDLE is ignored.
    dout_i[32*49 +: 32] = 32'hFFFFFFFF;
    pulse_done();
    rd(32'h2C4, 32'h12345678);
    rd(32'h404, 32'h0);

    // Reset in the middle of a run; the core's late done_i is ignored.
    wr(32'h400, 32'h1);
    idle(3);
    rst_i = 1'b1;
    #2;
    chk("midrst_rvalid", {31'h0, rvalid_o}, 32'h0);
    chk("midrst_din_zero", {31'h0, |din_o}, 32'h0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    pulse_done();
    rd(32'h2C4, 32'h0);
    rd(32'h404, 32'h0);
    rd(32'h800, 32'h0);
    rd(32'h408, 32'h0);
    chk("midrst_intr", {31'h0, intr_o}, 32'h0);

    idle(3);
    chk("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/keccak_obi_responder.md
# keccak_obi_responder

OBI slave responder that terminates the Keccak accelerator's external-crossbar slave port and connects it to the Keccak permutation core. It owns the 1600-bit input state register bank, captures the 1600-bit output state on completion, and exposes control/status registers. It stalls bus masters that try to overwrite the input state while a permutation is running, and raises a completion interrupt.

## Interface
- STATE_WORDS, 50: number of 32-bit state words (1600 bits).
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous, active-high reset.
- req_i  in  1  OBI request.
- we_i  in  1  OBI write enable.
- be_i  in  4  OBI byte enables.
- addr_i  in  32  OBI byte address; only bits [19:0] are decoded.
- wdata_i  in  32  OBI write data.
- gnt_o  out  1  OBI grant.
- rvalid_o  out  1  OBI response valid.
- rdata_o  out  32  OBI read data.
- start_o  out  1  one-cycle permutation start pulse to core.
- din_o  out  32*STATE_WORDS  input state; word k at bits [32k+31:32k].
- dout_i  in  32*STATE_WORDS  core output state.
- done_i  in  1  core completion pulse.
- intr_o  out  1  completion interrupt, level.

## Operation
- Register map, byte offsets within the window:
  - 0x000 + 4k, k < STATE_WORDS: DIN[k], R/W, byte enables honoured.
  - 0x200 + 4k: DOUT[k], RO, captured copy of dout_i.
  - 0x400 CTRL: write bit0=1 starts; reads 0.
  - 0x404 STATUS: bit0 busy, bit1 done (sticky, clear-on-read).
  - 0x408 IEN: bit0 interrupt enable, R/W.
  - Any other offset, including addr_i[19:11] ≠ 0: reads 0, writes ignored, still granted.
- FSM: IDLE → RUN on granted CTRL write with wdata_i[0]=1; RUN → IDLE on done_i.
- Entering RUN: start_o pulses, done cleared, busy=1.
- On done_i in RUN: DOUT ← dout_i, done set, busy cleared.
- done_i in IDLE is ignored: no capture, no done.
- CTRL start while RUN: granted, ignored.
- DIN write while RUN: gnt_o held low until IDLE, then granted. All other accesses are granted while RUN.
- Reads are never stalled.
- intr_o = done & IEN[0].

## Timing
- Reset values: gnt_o 0, rvalid_o 0, rdata_o 0, start_o 0, din_o 0, DOUT 0, intr_o 0, IEN 0, state IDLE.
- gnt_o is combinational from req_i, we_i, addr_i and the FSM state.
- rvalid_o asserts exactly 1 cycle after each granted request, for one cycle. rdata_o is valid with it and is 0 for writes.
- Back-to-back granted requests every cycle are sustained at full throughput.
- start_o rises the cycle after the granted CTRL write, and busy reads 1 from that cycle.
- DOUT, done and busy update on the done_i edge; intr_o follows 1 cycle after done_i.
- Stalled DIN write is granted in the first cycle the state is IDLE, i.e. 1 cycle after done_i.
- STATUS read coinciding with done_i: returns the pre-edge value. The clear applies only to a done bit that was already set, so a done bit newly set by that done_i survives.
- Start write coinciding with done_i in RUN: the write is ignored (state was RUN).
- Reset mid-run returns the block to IDLE and clears everything. The core is not reset by this block; its late done_i is ignored.

## Configuration
- KECCAK_IRQ_EN defined: IEN register implemented, intr_o as above.
- KECCAK_IRQ_EN undefined:
  - intr_o tied 0.
  - IEN reads 0 and writes are ignored.
  - done/STATUS behaviour unchanged.

## Test plan
- Reset, then read 0x404 → rvalid 1 cycle after gnt, rdata 0; intr_o 0.
- Write DIN[0]=0xDEADBEEF with be=0b0011, then read 0x000 → 0x0000BEEF; din_o[31:0]=0x0000BEEF.
- Write CTRL=1 → start_o one cycle later, STATUS=0x1. Drive done_i 24 cycles later with dout word 49=0x12345678.
  - Read 0x2C4 → 0x12345678.
  - Read 0x404 → 0x2; a second read → 0x0.
- During RUN, write DIN[3] → gnt_o low until the cycle after done_i, then DIN[3] updated. A concurrent DOUT read is granted immediately.
- With KECCAK_IRQ_EN defined: IEN=1, run → intr_o=1 one cycle after done_i, cleared by STATUS read. Without the macro → intr_o stays 0.
- Assert rst_i during RUN, then drive done_i → DOUT stays 0, STATUS=0; read of 0x800 → 0.
